rv_lsu: RTL and testbench

- Load/store unit between the RV64 execute stage and the single-port synchronous data memory (mem_sync_sp_rvdmem-style: 1-cycle registered read, per-byte write enables, write-first).
- Accepts one memory op per handshake and converts it to byte-lane writes or an aligned 64-bit read.
- Extracts and sign/zero-extends load data, flags misaligned and illegal ops, and returns one response per request over a valid/ready handshake.

---
 rtl/rv_lsu_pkg.sv | 43 ++++
 rtl/rv_lsu_if.sv | 43 ++++
 rtl/rv_lsu_align.sv | 84 ++++++++
 rtl/rv_lsu.sv | 156 +++++++++++++++
 tb/tb_rv_lsu.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_lsu_pkg.sv
// ---------------------------------------------------------------------------
// rv_lsu_pkg
// Shared definitions for the RV64 load/store unit:
//   - RISC-V load/store funct3 encodings
//   - FSM state type used by rv_lsu
//   - lane_mask(): byte-enable pattern for an access of 2**size bytes at a
//     byte offset within a 64-bit word
// ---------------------------------------------------------------------------
package rv_lsu_pkg;

  // funct3 encodings. For stores only the first four are valid; the low two
  // bits always give log2 of the access size in bytes.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a request
    MEM  = 2'd1,  // memory read data is being returned this cycle
    RESP = 2'd2   // response presented, waiting for rsp_ready
  } lsu_state_t;

  // Byte-lane mask of an access of (1 << size) bytes starting at lane off.
  // Callers only use the result for naturally aligned accesses, so the mask
  // never spills past lane 7.
  function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                           input logic [2:0] off);
    logic [7:0] base;
    base = 8'h00;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/rv_lsu_if.sv
// ---------------------------------------------------------------------------
// rv_lsu_if
// Request/response bundle between the execute stage and the load/store unit.
//   req_valid/req_ready  request handshake (fires when both are high)
//   req_we               1 = store, 0 = load
//   req_funct3           RISC-V funct3 of the access
//   req_addr             byte address
//   req_wdata            store data, right-aligned
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            extended load data (0 for stores and faults)
//   rsp_misaligned       address not naturally aligned for the access size
//   rsp_illegal          funct3 not valid for the op
// Modports: master = execute stage, slave = load/store unit.
// ---------------------------------------------------------------------------
interface rv_lsu_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_misaligned;
  logic                  rsp_illegal;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_illegal
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_illegal
  );

endinterface

// File: rtl/rv_lsu_align.sv
// ---------------------------------------------------------------------------
// rv_lsu_align
// Purely combinational data alignment for the load/store unit.
// Request side (decoded from the live request):
//   i_req_we, i_req_funct3, i_req_off, i_req_wdata
//   o_st_wdata     store data replicated across every lane so the addressed
//                  lanes hold the right-aligned value shifted by 8*off
//   o_lane_mask    byte enables of the access (valid when aligned)
//   o_misaligned   offset not a multiple of the access size
//   o_illegal      funct3 invalid for the op
// Load side (from the registered request and memory read data):
//   i_ld_funct3, i_ld_off, i_mem_rdata
//   o_ld_data      selected bytes, sign- or zero-extended
// Only DATA_WIDTH = 64 is supported.
// ---------------------------------------------------------------------------
module rv_lsu_align
  import rv_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DATA_BYTES = DATA_WIDTH / 8
) (
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [2:0]            i_req_off,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic [DATA_WIDTH-1:0] o_st_wdata,
  output logic [DATA_BYTES-1:0] o_lane_mask,
  output logic                  o_misaligned,
  output logic                  o_illegal,
  input  logic [2:0]            i_ld_funct3,
  input  logic [2:0]            i_ld_off,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_ld_data
);

  logic [1:0]            w_req_size;
  logic [DATA_WIDTH-1:0] w_ld_shifted;

  assign w_req_size = i_req_funct3[1:0];

  // Each lane takes the byte of the store value that lands on it when the
  // value is repeated every (1 << size) bytes. The addressed lanes therefore
  // carry wdata << 8*off, and the other lanes hold harmless copies.
  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_st_lane
    assign o_st_wdata[8*gi +: 8] =
        (w_req_size == 2'd0) ? i_req_wdata[7:0] :
        (w_req_size == 2'd1) ? i_req_wdata[8*(gi % 2) +: 8] :
        (w_req_size == 2'd2) ? i_req_wdata[8*(gi % 4) +: 8] :
                               i_req_wdata[8*gi +: 8];
  end

  assign o_lane_mask = lane_mask(w_req_size, i_req_off);

  always_comb begin
    o_misaligned = 1'b0;
    case (w_req_size)
      2'd0:    o_misaligned = 1'b0;
      2'd1:    o_misaligned = i_req_off[0];
      2'd2:    o_misaligned = |i_req_off[1:0];
      default: o_misaligned = |i_req_off;
    endcase
  end

  // Stores have no unsigned variants; the only invalid load encoding is 111.
  assign o_illegal = i_req_we ? i_req_funct3[2] : (i_req_funct3 == 3'b111);

  // The memory always returns the whole aligned word; move the addressed
  // bytes down to bit 0 before extending.
  assign w_ld_shifted = i_mem_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    o_ld_data = '0;
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{(DATA_WIDTH-8){w_ld_shifted[7]}},   w_ld_shifted[7:0]};
      F3_H:    o_ld_data = {{(DATA_WIDTH-16){w_ld_shifted[15]}}, w_ld_shifted[15:0]};
      F3_W:    o_ld_data = {{(DATA_WIDTH-32){w_ld_shifted[31]}}, w_ld_shifted[31:0]};
      F3_BU:   o_ld_data = {{(DATA_WIDTH-8){1'b0}},  w_ld_shifted[7:0]};
      F3_HU:   o_ld_data = {{(DATA_WIDTH-16){1'b0}}, w_ld_shifted[15:0]};
      F3_WU:   o_ld_data = {{(DATA_WIDTH-32){1'b0}}, w_ld_shifted[31:0]};
      default: o_ld_data = w_ld_shifted;  // LD; 111 never gets this far
    endcase
  end

endmodule

// File: rtl/rv_lsu.sv
// ---------------------------------------------------------------------------
// rv_lsu
// RV64 load/store unit between the execute stage and a single-port
// synchronous data memory (1-cycle registered read, per-byte write enables,
// write-first). One memory op per request, one response per request.
// Ports:
//   clk        clock, all state on posedge
//   rst        synchronous active-high reset
//   lsu        request/response bundle (rv_lsu_if.slave)
//   mem_addr   memory address (full, unmodified byte address)
//   mem_wdata  memory write data
//   mem_wen    memory per-byte write enables
//   mem_rdata  memory read data (valid the cycle after the address)
// Timing for a legal aligned op firing at edge N: the store is written at N,
// the read word is captured at N+1 and the response is valid afterwards.
// Faulting ops skip MEM and present their response right after N.
// ---------------------------------------------------------------------------
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DATA_BYTES = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  rv_lsu_if.slave               lsu,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_BYTES-1:0] mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t r_state;
  lsu_state_t w_state_next;

  // Request captured at fire; drives mem_addr and load extraction later.
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_funct3;
  logic                  r_we;

  // Registered response.
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_misaligned;
  logic                  r_rsp_illegal;

  logic                  w_req_ready;
  logic                  w_fire;
  logic                  w_fault;
  logic [DATA_WIDTH-1:0] w_st_wdata;
  logic [DATA_BYTES-1:0] w_lane_mask;
  logic                  w_misaligned;
  logic                  w_illegal;
  logic [DATA_WIDTH-1:0] w_ld_data;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_BYTES-1:0] w_mem_wen;

  rv_lsu_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_BYTES (DATA_BYTES)
  ) u_align (
    .i_req_we     (lsu.req_we),
    .i_req_funct3 (lsu.req_funct3),
    .i_req_off    (lsu.req_addr[2:0]),
    .i_req_wdata  (lsu.req_wdata),
    .o_st_wdata   (w_st_wdata),
    .o_lane_mask  (w_lane_mask),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal),
    .i_ld_funct3  (r_funct3),
    .i_ld_off     (r_addr[2:0]),
    .i_mem_rdata  (mem_rdata),
    .o_ld_data    (w_ld_data)
  );

  assign w_fault = w_misaligned | w_illegal;
  assign w_fire  = w_req_ready & lsu.req_valid;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_mem_addr   = r_addr;
    w_mem_wen    = '0;
    case (r_state)
      IDLE: begin
        // Present the live address so the memory's registered read lines
        // up with the MEM cycle; gating on rst blocks writes during reset.
        w_req_ready = !rst;
        w_mem_addr  = lsu.req_addr;
        if (lsu.req_valid && !rst) begin
          w_state_next = w_fault ? RESP : MEM;
          if (lsu.req_we && !w_fault) begin
            w_mem_wen = w_lane_mask;
          end
        end
      end
      MEM: begin
        w_state_next = RESP;
      end
      RESP: begin
        if (lsu.rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr           <= '0;
      r_funct3         <= '0;
      r_we             <= 1'b0;
      r_rsp_rdata      <= '0;
      r_rsp_misaligned <= 1'b0;
      r_rsp_illegal    <= 1'b0;
    end else if (w_fire) begin
      r_addr           <= lsu.req_addr;
      r_funct3         <= lsu.req_funct3;
      r_we             <= lsu.req_we;
      // Faults respond straight away with zero data; legal ops get their
      // data in MEM. Illegal masks misaligned so only one flag is reported.
      r_rsp_rdata      <= '0;
      r_rsp_illegal    <= w_illegal;
      r_rsp_misaligned <= w_misaligned & ~w_illegal;
    end else if (r_state == MEM) begin
      // mem_rdata is sampled exactly once per op, so read side effects
      // (e.g. a cycle counter location) are observed once.
      r_rsp_rdata <= r_we ? '0 : w_ld_data;
    end
  end

  // -------------------------------------------------------------- outputs
  assign lsu.req_ready      = w_req_ready;
  assign lsu.rsp_valid      = (r_state == RESP);
  assign lsu.rsp_rdata      = r_rsp_rdata;
  assign lsu.rsp_misaligned = r_rsp_misaligned;
  assign lsu.rsp_illegal    = r_rsp_illegal;

  assign mem_addr  = w_mem_addr;
  assign mem_wdata = w_st_wdata;
  assign mem_wen   = w_mem_wen;

endmodule

// File: tb/tb_rv_lsu.sv
// ---------------------------------------------------------------------------
// tb_rv_lsu
// Directed bench for rv_lsu with a behavioural single-port data memory
// (registered read, byte writes, write-first, putc at 0x40, halt at 0x50,
// cycle counter read at 0x60).
// ---------------------------------------------------------------------------
module tb_rv_lsu;
  import rv_lsu_pkg::*;

  localparam logic [63:0] SENTINEL = 64'h5A5A_5A5A_5A5A_5A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_lsu_if bus ();

  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wen;
  logic [63:0] mem_rdata;

  rv_lsu dut (
    .clk       (clk),
    .rst       (rst),
    .lsu       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata)
  );

  // ------------------------------------------------------- memory model
  logic [63:0] mem [128];
  logic        mem_clr = 1'b1;
  logic [63:0] cyc = 64'd0;
  int          putc_cnt = 0;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 64'd1;
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) mem[i] <= (i == 8) ? SENTINEL : 64'd0;
      mem_rdata <= '0;
    end else if (mem_addr == 64'h40 || mem_addr == 64'h50) begin
      if (mem_addr == 64'h40 && mem_wen != 8'h00) begin
        $display("mem putc '%c'", mem_wdata[7:0]);
        putc_cnt <= putc_cnt + 1;
      end
      mem_rdata <= '0;
    end else if (mem_addr == 64'h60) begin
      mem_rdata <= cyc;
    end else begin
      mem_rdata <= merge(mem[mem_addr[9:3]], mem_wdata, mem_wen);
      if (mem_wen != 8'h00) mem[mem_addr[9:3]] <= merge(mem[mem_addr[9:3]], mem_wdata, mem_wen);
    end
  end

  // ------------------------------------------------------------ helpers
  int n_chk  = 0;
  int n_fail = 0;

  logic        f_rdy;
  logic [7:0]  f_wen;
  logic [63:0] f_wdata;
  logic [63:0] f_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, samples the combinational memory outputs just
  // before the firing edge, and returns one tick after that edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    #1;
    f_rdy   = bus.req_ready;
    f_wen   = mem_wen;
    f_wdata = mem_wdata;
    f_addr  = mem_addr;
    $display("txn %s f3=%0d addr=%h wdata=%h", we ? "store" : "load ", f3, addr, wd);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  // -------------------------------------------------------------- tests
  task automatic test_reset();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_D;
    bus.req_addr = 64'h1F8; bus.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(); tick();
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid: got %b want 0", bus.rsp_valid); end
    n_chk++; if (bus.rsp_rdata !== 64'd0) begin n_fail++; $display("FAIL reset rsp_rdata: got %h want 0", bus.rsp_rdata); end
    n_chk++; if ({bus.rsp_misaligned, bus.rsp_illegal} !== 2'b00) begin n_fail++; $display("FAIL reset flags: got %b want 00", {bus.rsp_misaligned, bus.rsp_illegal}); end
    n_chk++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset req_ready: got %b want 0", bus.req_ready); end
    n_chk++; if (mem_wen !== 8'h00) begin n_fail++; $display("FAIL reset mem_wen: got %h want 00", mem_wen); end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset release req_ready: got %b want 1", bus.req_ready); end
    n_chk++; if (mem[63] !== 64'd0) begin n_fail++; $display("FAIL reset no write: got %h want 0", mem[63]); end
    tick();
  endtask

  task automatic test_sd_ld();
    issue(1'b1, F3_D, 64'h100, 64'h1122_3344_5566_7788);
    n_chk++; if (f_rdy !== 1'b1) begin n_fail++; $display("FAIL sd req_ready: got %b want 1", f_rdy); end
    n_chk++; if (f_wen !== 8'hFF) begin n_fail++; $display("FAIL sd mem_wen: got %h want ff", f_wen); end
    n_chk++; if (f_wdata !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL sd mem_wdata: got %h want 1122334455667788", f_wdata); end
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sd early rsp_valid: got %b want 0", bus.rsp_valid); end
    tick();
    n_chk++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sd rsp_valid: got %b want 1", bus.rsp_valid); end
    n_chk++; if (bus.rsp_rdata !== 64'd0) begin n_fail++; $display("FAIL sd rsp_rdata: got %h want 0", bus.rsp_rdata); end
    finish_rsp();
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sd rsp drop: got %b want 0", bus.rsp_valid); end

    issue(1'b0, F3_D, 64'h100, 64'd0);
    n_chk++; if (f_wen !== 8'h00) begin n_fail++; $display("FAIL ld mem_wen: got %h want 00", f_wen); end
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ld early rsp_valid: got %b want 0", bus.rsp_valid); end
    tick();
    n_chk++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL ld rsp_valid: got %b want 1", bus.rsp_valid); end
    n_chk++; if (bus.rsp_rdata !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL ld rsp_rdata: got %h want 1122334455667788", bus.rsp_rdata); end
    finish_rsp();
  endtask

  logic [2:0]  ext_f3  [8] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W, F3_WU, F3_W, F3_D};
  logic [63:0] ext_ad  [8] = '{64'h103, 64'h103, 64'h102, 64'h106, 64'h104, 64'h100, 64'h100, 64'h100};
  logic [63:0] ext_exp [8] = '{64'hFFFF_FFFF_FFFF_FFAB, 64'h0000_0000_0000_00AB,
                               64'hFFFF_FFFF_FFFF_AB66, 64'h0000_0000_0000_1122,
                               64'h0000_0000_1122_3344, 64'h0000_0000_AB66_7788,
                               64'hFFFF_FFFF_AB66_7788, 64'h1122_3344_AB66_7788};

  task automatic test_byte_store_load_ext();
    issue(1'b1, F3_B, 64'h103, 64'hDEAD_BEEF_CAFE_12AB);
    n_chk++; if (f_wen !== 8'h08) begin n_fail++; $display("FAIL sb mem_wen: got %h want 08", f_wen); end
    n_chk++; if (f_wdata[31:24] !== 8'hAB) begin n_fail++; $display("FAIL sb mem_wdata lane3: got %h want ab", f_wdata[31:24]); end
    tick();
    finish_rsp();
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, ext_f3[i], ext_ad[i], 64'd0);
      tick();
      n_chk++; if (bus.rsp_rdata !== ext_exp[i]) begin n_fail++; $display("FAIL load_ext[%0d] rsp_rdata: got %h want %h", i, bus.rsp_rdata, ext_exp[i]); end
      finish_rsp();
    end
  endtask

  task automatic test_faults();
    issue(1'b0, F3_H, 64'h101, 64'd0);
    n_chk++; if (f_wen !== 8'h00) begin n_fail++; $display("FAIL lh_mis mem_wen: got %h want 00", f_wen); end
    n_chk++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL lh_mis rsp_valid: got %b want 1", bus.rsp_valid); end
    n_chk++; if ({bus.rsp_misaligned, bus.rsp_illegal} !== 2'b10) begin n_fail++; $display("FAIL lh_mis flags: got %b want 10", {bus.rsp_misaligned, bus.rsp_illegal}); end
    n_chk++; if (bus.rsp_rdata !== 64'd0) begin n_fail++; $display("FAIL lh_mis rsp_rdata: got %h want 0", bus.rsp_rdata); end
    finish_rsp();

    issue(1'b0, 3'b111, 64'h100, 64'd0);
    n_chk++; if ({bus.rsp_valid, bus.rsp_misaligned, bus.rsp_illegal} !== 3'b101) begin n_fail++; $display("FAIL ld111 valid/flags: got %b want 101", {bus.rsp_valid, bus.rsp_misaligned, bus.rsp_illegal}); end
    finish_rsp();

    issue(1'b1, 3'b101, 64'h101, 64'hFFFF);
    n_chk++; if (f_wen !== 8'h00) begin n_fail++; $display("FAIL st101 mem_wen: got %h want 00", f_wen); end
    n_chk++; if ({bus.rsp_valid, bus.rsp_misaligned, bus.rsp_illegal} !== 3'b101) begin n_fail++; $display("FAIL st101 valid/flags: got %b want 101", {bus.rsp_valid, bus.rsp_misaligned, bus.rsp_illegal}); end
    finish_rsp();

    issue(1'b1, F3_W, 64'h102, 64'h0);
    n_chk++; if (f_wen !== 8'h00) begin n_fail++; $display("FAIL sw_mis mem_wen: got %h want 00", f_wen); end
    n_chk++; if ({bus.rsp_valid, bus.rsp_misaligned, bus.rsp_illegal} !== 3'b110) begin n_fail++; $display("FAIL sw_mis valid/flags: got %b want 110", {bus.rsp_valid, bus.rsp_misaligned, bus.rsp_illegal}); end
    finish_rsp();

    issue(1'b0, F3_D, 64'h100, 64'd0);
    tick();
    n_chk++; if (bus.rsp_rdata !== 64'h1122_3344_AB66_7788) begin n_fail++; $display("FAIL faults memory intact: got %h want 11223344ab667788", bus.rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    issue(1'b0, F3_W, 64'h104, 64'd0);
    tick();
    // A store is offered while the response is held; it must wait.
    bus.req_we = 1'b1; bus.req_funct3 = F3_D; bus.req_addr = 64'h108;
    bus.req_wdata = 64'h0123_4567_89AB_CDEF; bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL hold[%0d] rsp_valid: got %b want 1", i, bus.rsp_valid); end
      n_chk++; if (bus.rsp_rdata !== 64'h0000_0000_1122_3344) begin n_fail++; $display("FAIL hold[%0d] rsp_rdata: got %h want 11223344", i, bus.rsp_rdata); end
      n_chk++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL hold[%0d] req_ready: got %b want 0", i, bus.req_ready); end
      n_chk++; if (mem_wen !== 8'h00) begin n_fail++; $display("FAIL hold[%0d] mem_wen: got %h want 00", i, mem_wen); end
      n_chk++; if (mem_addr !== 64'h104) begin n_fail++; $display("FAIL hold[%0d] mem_addr: got %h want 104", i, mem_addr); end
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_chk++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL handshake cycle req_ready: got %b want 0", bus.req_ready); end
    tick();
    bus.rsp_ready = 1'b0;
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL after hs rsp_valid: got %b want 0", bus.rsp_valid); end
    n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL after hs req_ready: got %b want 1", bus.req_ready); end
    n_chk++; if (mem_wen !== 8'hFF || mem_addr !== 64'h108) begin n_fail++; $display("FAIL after hs accept: got wen %h addr %h want ff 108", mem_wen, mem_addr); end
    tick();
    bus.req_valid = 1'b0;
    tick();
    n_chk++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL held store rsp_valid: got %b want 1", bus.rsp_valid); end
    finish_rsp();
    issue(1'b0, F3_D, 64'h108, 64'd0);
    tick();
    n_chk++; if (bus.rsp_rdata !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL held store readback: got %h want 0123456789abcdef", bus.rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_reset_mid_op();
    issue(1'b1, F3_W, 64'h110, 64'hFFFF_0000_CAFE_BABE);
    n_chk++; if (f_wen !== 8'h0F) begin n_fail++; $display("FAIL sw mem_wen: got %h want 0f", f_wen); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst rsp_valid: got %b want 0", bus.rsp_valid); end
    n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst idle req_ready: got %b want 1", bus.req_ready); end
    tick(); tick();
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst late rsp_valid: got %b want 0", bus.rsp_valid); end
    issue(1'b0, F3_W, 64'h110, 64'd0);
    tick();
    n_chk++; if (bus.rsp_rdata !== 64'hFFFF_FFFF_CAFE_BABE) begin n_fail++; $display("FAIL midrst readback: got %h want ffffffffcafebabe", bus.rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_ctrl_addr();
    issue(1'b1, F3_B, 64'h40, 64'h41);
    n_chk++; if (f_wen !== 8'h01 || f_addr !== 64'h40) begin n_fail++; $display("FAIL putc bus: got wen %h addr %h want 01 40", f_wen, f_addr); end
    tick();
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 64'd0) begin n_fail++; $display("FAIL putc rsp: got valid %b rdata %h want 1 0", bus.rsp_valid, bus.rsp_rdata); end
    n_chk++; if (putc_cnt !== 1) begin n_fail++; $display("FAIL putc count: got %0d want 1", putc_cnt); end
    n_chk++; if (mem[8] !== SENTINEL) begin n_fail++; $display("FAIL putc array: got %h want %h", mem[8], SENTINEL); end
    finish_rsp();
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    tick();
    mem_clr = 1'b0;
    test_reset();
    test_sd_ld();
    test_byte_store_load_ext();
    test_faults();
    test_backpressure();
    test_reset_mid_op();
    test_ctrl_addr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
